// File: rtl/deinterleaver_60bit.sv
// Column-to-row deinterleaver for a 4 x 15 bit frame with a double-buffered output.
// Optional: define DEINT_FRAME_CNT_EN to add a 16-bit frame_cnt output counting consumed frames.
module deinterleaver_60bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_col,
    input  logic        s_sof,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [59:0] m_data,
    output logic        err_sync
`ifdef DEINT_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int         ROWS     = 4;
    localparam logic [3:0] LAST_COL = 4'd14;

    logic [3:0]  col_cnt_q,  col_cnt_d;
    logic [59:0] buf_q,      buf_d;
    logic [59:0] m_data_q,   m_data_d;
    logic        m_valid_q,  m_valid_d;
    logic        err_sync_q, err_sync_d;
    logic        s_accept;
    logic        m_take;

    // Columns 0..13 only fill the collect buffer; the closing column needs the output slot.
    assign s_ready  = (col_cnt_q != LAST_COL) || !m_valid_q || m_ready;
    assign s_accept = s_valid && s_ready;
    assign m_take   = m_valid_q && m_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        col_cnt_d  = col_cnt_q;
        buf_d      = buf_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q && !m_ready;
        err_sync_d = 1'b0;

        if (s_accept) begin
            if (s_sof) begin
                // Start of frame always restarts; any partial frame is a sync error.
                err_sync_d = (col_cnt_q != 4'd0);
                buf_d      = '0;
                for (int r = 0; r < ROWS; r++) begin
                    buf_d[15*r] = s_col[r];
                end
                col_cnt_d = 4'd1;
            end else if (col_cnt_q == 4'd0) begin
                err_sync_d = 1'b1;
            end else begin
                for (int r = 0; r < ROWS; r++) begin
                    buf_d[15*r + int'(col_cnt_q)] = s_col[r];
                end
                if (col_cnt_q == LAST_COL) begin
                    m_data_d  = buf_d;
                    m_valid_d = 1'b1;
                    col_cnt_d = 4'd0;
                end else begin
                    col_cnt_d = col_cnt_q + 4'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q  <= '0;
            buf_q      <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            err_sync_q <= 1'b0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            buf_q      <= buf_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            err_sync_q <= err_sync_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign err_sync = err_sync_q;

`ifdef DEINT_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (m_take) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    logic unused_take;
    assign unused_take = m_take;
`endif

endmodule

// File: tb/tb_deinterleaver_60bit.sv
// Scoreboard bench for deinterleaver_60bit: a frame-level model predicts outputs and sync errors.
module tb_deinterleaver_60bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_col;
    logic        s_sof;
    logic        m_valid;
    logic        m_ready;
    logic [59:0] m_data;
    logic        err_sync;
`ifdef DEINT_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    deinterleaver_60bit dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_col    (s_col),
        .s_sof    (s_sof),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .err_sync (err_sync)
`ifdef DEINT_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [59:0] exp_q[$];
    logic [3:0]  part_q[$];
    bit          err_pending = 0;
    bit          err_expect  = 0;
    int          rdy_mode    = 2;   // 0 random, 1 hold low, 2 hold high
    bit          prev_stall  = 0;
    logic [59:0] prev_data   = '0;
    int          hs_count    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] col_of(input logic [59:0] word, input int k);
        logic [3:0] c;
        for (int r = 0; r < 4; r++) c[r] = word[15*r + k];
        return c;
    endfunction

    // Reference: a frame is any sof beat followed by 14 plain beats; anything else is a sync error.
    task automatic model_accept(input logic [3:0] col, input logic sof);
        logic [59:0] w;
        if (sof) begin
            if (part_q.size() != 0) err_pending = 1;
            part_q.delete();
            part_q.push_back(col);
        end else if (part_q.size() == 0) begin
            err_pending = 1;
        end else begin
            part_q.push_back(col);
        end
        if (part_q.size() == 15) begin
            w = '0;
            for (int k = 0; k < 15; k++)
                for (int r = 0; r < 4; r++) w[15*r + k] = part_q[k][r];
            exp_q.push_back(w);
            part_q.delete();
        end
    endtask

    always @(posedge clk) begin
        err_expect  = err_pending;
        err_pending = 0;
    end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = ($urandom_range(0, 3) != 0);
                1:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares presented frames, stall stability, sync-error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_sync || err_expect) check("err_sync", err_sync, err_expect);
            if (prev_stall) check("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_frame", m_data, 60'h0);
                else check("frame", m_data, exp_q.pop_front());
`ifdef DEINT_FRAME_CNT_EN
                check("frame_cnt", frame_cnt, hs_count[15:0]);
`endif
                hs_count++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            s_col   = 4'($urandom);
            s_sof   = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [3:0] col, input logic sof);
        int waited = 0;
        bit done   = 0;
        s_valid = 1'b1;
        s_col   = col;
        s_sof   = sof;
        while (!done && waited < 400) begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(col, sof);
                done = 1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        s_valid = 1'b0;
        if (!done) check("beat_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_frame(input logic [59:0] word, input int first, input int last, input bit gaps);
        for (int k = first; k <= last; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_beat(col_of(word, k), k == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        part_q.delete();
        exp_q.delete();
        err_pending = 0;
        err_expect  = 0;
        prev_stall  = 0;
        hs_count    = 0;
    endtask

    logic [59:0] fa, fb, fw;
    int          wait_cnt;

    initial begin
        s_valid = 1'b0;
        s_col   = '0;
        s_sof   = 1'b0;
        do_reset();
        #3;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 60'h0);
        check("rst_err_sync", err_sync, 1'b0);
        check("rst_s_ready", s_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_s_ready", s_ready, 1'b1);

        // Single-row frame with one cycle latency.
        rdy_mode = 2;
        idle(1);
        fw = 60'h0000000_00007FFF;
        for (int k = 0; k < 15; k++) check("row0_col", col_of(fw, k), 4'b0001);
        send_frame(fw, 0, 14, 0);
        check("latency_m_valid", m_valid, 1'b1);
        check("latency_m_data", m_data, fw);

        send_frame(60'h123456789ABCDEF, 0, 14, 0);

        // Back-pressure: A held, B's closing beat waits for the slot.
        rdy_mode = 1;
        idle(1);
        fa = 60'hA5A5_1234_5678_9AB;
        fb = 60'h0F0_F0F0_CAFE_BEEF;
        send_frame(fa, 0, 14, 0);
        send_frame(fb, 0, 13, 0);
        s_valid = 1'b1;
        s_col   = col_of(fb, 14);
        s_sof   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_s_ready", s_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        check("stall_data_a", m_data, fa);
        rdy_mode = 2;
        send_beat(col_of(fb, 14), 1'b0);
        check("b_presented", {m_valid, m_data}, {1'b1, fb});

        // Early sof on the 8th beat.
        fw = 60'h7E1_2B3C_4D5E_6F70;
        send_frame(fw, 0, 6, 0);
        fw = 60'h0C3_A596_0F1E_2D3C;
        send_frame(fw, 0, 14, 0);
        idle(3);

        // Reset mid-frame.
        fw = 60'h55A_AA55_1357_9BDF;
        send_frame(fw, 0, 6, 0);
        do_reset();
        #1;
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_m_data", m_data, 60'h0);
        check("midrst_s_ready", s_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(col_of(fw, 7), 1'b0);
        idle(5);
        check("no_frame_after_rst", m_valid, 1'b0);

        // Randomised traffic with occasional framing faults.
        rdy_mode = 0;
        for (int f = 0; f < 30; f++) begin
            fw = {28'($urandom), 32'($urandom)};
            case ($urandom_range(0, 7))
                0: send_beat(4'($urandom), 1'b0);
                1: send_frame(fw, 0, $urandom_range(0, 13), 1);
                default: ;
            endcase
            fw = {28'($urandom), 32'($urandom)};
            send_frame(fw, 0, 14, 1);
        end

        rdy_mode = 2;
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 100) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        idle(2);
        check("drain_empty", exp_q.size(), 0);
        check("final_m_valid", m_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
